// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection,
// branch/jump flush and EX hold for multi-cycle operations.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          ID_RegDst,
  input  logic          ID_MemRead,
  input  logic          ID_MemToReg,
  input  logic          ID_MemWrite,
  input  logic          ID_ALUSrc,
  input  logic          ID_RegWrite,
  input  logic          ID_jal,
  input  logic [3:0]    ID_ALUOp,
  input  logic [1:0]    ID_BranchType,
  input  logic [DW-1:0] ID_ReadData1,
  input  logic [DW-1:0] ID_ReadData2,
  input  logic [DW-1:0] ID_Imm,
  input  logic [DW-1:0] ID_PCPlus4,
  input  logic [RW-1:0] ID_Rs,
  input  logic [RW-1:0] ID_Rt,
  input  logic [RW-1:0] ID_Rd,
  input  logic          Flush,
  input  logic          HoldEX,
  output logic          EX_RegDst,
  output logic          EX_MemRead,
  output logic          EX_MemToReg,
  output logic          EX_MemWrite,
  output logic          EX_ALUSrc,
  output logic          EX_RegWrite,
  output logic          EX_jal,
  output logic [3:0]    EX_ALUOp,
  output logic [1:0]    EX_BranchType,
  output logic [DW-1:0] EX_ReadData1,
  output logic [DW-1:0] EX_ReadData2,
  output logic [DW-1:0] EX_Imm,
  output logic [DW-1:0] EX_PCPlus4,
  output logic [RW-1:0] EX_Rs,
  output logic [RW-1:0] EX_Rt,
  output logic [RW-1:0] EX_Rd,
  output logic          EX_Valid,
  output logic          StallIF
);

  typedef struct packed {
    logic          regDst;
    logic          memRead;
    logic          memToReg;
    logic          memWrite;
    logic          aluSrc;
    logic          regWrite;
    logic          jal;
    logic [3:0]    aluOp;
    logic [1:0]    branchType;
    logic [DW-1:0] readData1;
    logic [DW-1:0] readData2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pcPlus4;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic          valid;
  } id_ex_t;

  id_ex_t ex;
  id_ex_t idPkt;
  logic   usesRs;
  logic   usesRt;
  logic   hazard;

  // Bundle the ID-stage instruction as it would appear in EX.
  always_comb begin
    idPkt            = '0;
    idPkt.regDst     = ID_RegDst;
    idPkt.memRead    = ID_MemRead;
    idPkt.memToReg   = ID_MemToReg;
    idPkt.memWrite   = ID_MemWrite;
    idPkt.aluSrc     = ID_ALUSrc;
    idPkt.regWrite   = ID_RegWrite;
    idPkt.jal        = ID_jal;
    idPkt.aluOp      = ID_ALUOp;
    idPkt.branchType = ID_BranchType;
    idPkt.readData1  = ID_ReadData1;
    idPkt.readData2  = ID_ReadData2;
    idPkt.imm        = ID_Imm;
    idPkt.pcPlus4    = ID_PCPlus4;
    idPkt.rs         = ID_Rs;
    idPkt.rt         = ID_Rt;
    idPkt.rd         = ID_Rd;
    idPkt.valid      = 1'b1;
  end

  // Operand use of the ID instruction and load-use detection.
  always_comb begin
    usesRs = (ID_BranchType != 2'd1);
    usesRt = ID_RegDst | ID_MemWrite
           | ((ID_BranchType == 2'd3)
              & ((ID_ALUOp == 4'b0100)
                 | (ID_ALUOp == 4'b0101)));
    hazard = ex.valid & ex.memRead
           & (ex.rt != '0)
           & ((usesRs & (ID_Rs == ex.rt))
              | (usesRt & (ID_Rt == ex.rt)));
    StallIF = (hazard | HoldEX) & ~Flush;
  end

  // EX register: flush > hold > bubble on hazard > capture.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ex <= '0;
    end else if (Flush) begin
      ex <= '0;
    end else if (HoldEX) begin
      ex <= ex;
    end else if (hazard) begin
      ex <= '0;
    end else begin
      ex <= idPkt;
    end
  end

  assign EX_RegDst     = ex.regDst;
  assign EX_MemRead    = ex.memRead;
  assign EX_MemToReg   = ex.memToReg;
  assign EX_MemWrite   = ex.memWrite;
  assign EX_ALUSrc     = ex.aluSrc;
  assign EX_RegWrite   = ex.regWrite;
  assign EX_jal        = ex.jal;
  assign EX_ALUOp      = ex.aluOp;
  assign EX_BranchType = ex.branchType;
  assign EX_ReadData1  = ex.readData1;
  assign EX_ReadData2  = ex.readData2;
  assign EX_Imm        = ex.imm;
  assign EX_PCPlus4    = ex.pcPlus4;
  assign EX_Rs         = ex.rs;
  assign EX_Rt         = ex.rt;
  assign EX_Rd         = ex.rd;
  assign EX_Valid      = ex.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents
// are queued at drive time and compared after each edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic        regDst;
    logic        memRead;
    logic        memToReg;
    logic        memWrite;
    logic        aluSrc;
    logic        regWrite;
    logic        jal;
    logic [3:0]  aluOp;
    logic [1:0]  bt;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } idv_t;

  typedef struct packed {
    idv_t id;
    logic valid;
  } exv_t;

  logic        Clk, Rst;
  logic        ID_RegDst, ID_MemRead, ID_MemToReg;
  logic        ID_MemWrite, ID_ALUSrc, ID_RegWrite, ID_jal;
  logic [3:0]  ID_ALUOp;
  logic [1:0]  ID_BranchType;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PCPlus4;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic        Flush, HoldEX;
  logic        EX_RegDst, EX_MemRead, EX_MemToReg;
  logic        EX_MemWrite, EX_ALUSrc, EX_RegWrite, EX_jal;
  logic [3:0]  EX_ALUOp;
  logic [1:0]  EX_BranchType;
  logic [31:0] EX_ReadData1, EX_ReadData2, EX_Imm, EX_PCPlus4;
  logic [4:0]  EX_Rs, EX_Rt, EX_Rd;
  logic        EX_Valid, StallIF;

  int   nVec = 0;
  int   nMis = 0;
  exv_t q[$];
  exv_t mEx;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .Clk(Clk), .Rst(Rst),
    .ID_RegDst(ID_RegDst), .ID_MemRead(ID_MemRead),
    .ID_MemToReg(ID_MemToReg), .ID_MemWrite(ID_MemWrite),
    .ID_ALUSrc(ID_ALUSrc), .ID_RegWrite(ID_RegWrite),
    .ID_jal(ID_jal), .ID_ALUOp(ID_ALUOp),
    .ID_BranchType(ID_BranchType),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .ID_PCPlus4(ID_PCPlus4),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .Flush(Flush), .HoldEX(HoldEX),
    .EX_RegDst(EX_RegDst), .EX_MemRead(EX_MemRead),
    .EX_MemToReg(EX_MemToReg), .EX_MemWrite(EX_MemWrite),
    .EX_ALUSrc(EX_ALUSrc), .EX_RegWrite(EX_RegWrite),
    .EX_jal(EX_jal), .EX_ALUOp(EX_ALUOp),
    .EX_BranchType(EX_BranchType),
    .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
    .EX_Imm(EX_Imm), .EX_PCPlus4(EX_PCPlus4),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .EX_Valid(EX_Valid), .StallIF(StallIF)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic drive(input idv_t v);
    ID_RegDst     = v.regDst;
    ID_MemRead    = v.memRead;
    ID_MemToReg   = v.memToReg;
    ID_MemWrite   = v.memWrite;
    ID_ALUSrc     = v.aluSrc;
    ID_RegWrite   = v.regWrite;
    ID_jal        = v.jal;
    ID_ALUOp      = v.aluOp;
    ID_BranchType = v.bt;
    ID_ReadData1  = v.rd1;
    ID_ReadData2  = v.rd2;
    ID_Imm        = v.imm;
    ID_PCPlus4    = v.pc;
    ID_Rs         = v.rs;
    ID_Rt         = v.rt;
    ID_Rd         = v.rd;
  endtask

  function automatic exv_t readEx();
    exv_t r;
    r.id.regDst   = EX_RegDst;
    r.id.memRead  = EX_MemRead;
    r.id.memToReg = EX_MemToReg;
    r.id.memWrite = EX_MemWrite;
    r.id.aluSrc   = EX_ALUSrc;
    r.id.regWrite = EX_RegWrite;
    r.id.jal      = EX_jal;
    r.id.aluOp    = EX_ALUOp;
    r.id.bt       = EX_BranchType;
    r.id.rd1      = EX_ReadData1;
    r.id.rd2      = EX_ReadData2;
    r.id.imm      = EX_Imm;
    r.id.pc       = EX_PCPlus4;
    r.id.rs       = EX_Rs;
    r.id.rt       = EX_Rt;
    r.id.rd       = EX_Rd;
    r.valid       = EX_Valid;
    return r;
  endfunction

  function automatic idv_t base(input logic [4:0] rs,
                                input logic [4:0] rt,
                                input logic [4:0] rd);
    idv_t v;
    v     = '0;
    v.rd1 = $urandom();
    v.rd2 = $urandom();
    v.imm = $urandom();
    v.pc  = $urandom();
    v.rs  = rs;
    v.rt  = rt;
    v.rd  = rd;
    return v;
  endfunction

  function automatic idv_t fAdd(input logic [4:0] rd,
                                input logic [4:0] rs,
                                input logic [4:0] rt);
    idv_t v;
    v = base(rs, rt, rd);
    v.regDst   = 1'b1;
    v.regWrite = 1'b1;
    v.aluOp    = 4'b0010;
    return v;
  endfunction

  function automatic idv_t fMul(input logic [4:0] rd,
                                input logic [4:0] rs,
                                input logic [4:0] rt);
    idv_t v;
    v = fAdd(rd, rs, rt);
    v.aluOp = 4'b1111;
    return v;
  endfunction

  function automatic idv_t fLw(input logic [4:0] rt,
                               input logic [4:0] rs);
    idv_t v;
    v = base(rs, rt, 5'd0);
    v.memRead  = 1'b1;
    v.memToReg = 1'b1;
    v.aluSrc   = 1'b1;
    v.regWrite = 1'b1;
    return v;
  endfunction

  function automatic idv_t fAddi(input logic [4:0] rt,
                                 input logic [4:0] rs);
    idv_t v;
    v = base(rs, rt, 5'd0);
    v.aluSrc   = 1'b1;
    v.regWrite = 1'b1;
    v.aluOp    = 4'b0010;
    return v;
  endfunction

  function automatic idv_t fSw(input logic [4:0] rt,
                               input logic [4:0] rs);
    idv_t v;
    v = base(rs, rt, 5'd0);
    v.memWrite = 1'b1;
    v.aluSrc   = 1'b1;
    return v;
  endfunction

  function automatic idv_t fBeq(input logic [4:0] rs,
                                input logic [4:0] rt);
    idv_t v;
    v = base(rs, rt, 5'd0);
    v.bt    = 2'd3;
    v.aluOp = 4'b0100;
    return v;
  endfunction

  function automatic idv_t fJ(input logic [4:0] junk);
    idv_t v;
    v = base(junk, junk, 5'd0);
    v.bt = 2'd1;
    return v;
  endfunction

  function automatic logic modelHaz(input idv_t v);
    logic uRs, uRt;
    uRs = (v.bt != 2'd1);
    uRt = v.regDst | v.memWrite
        | ((v.bt == 2'd3)
           & ((v.aluOp == 4'd4) | (v.aluOp == 4'd5)));
    return mEx.valid & mEx.id.memRead
         & (mEx.id.rt != 5'd0)
         & ((uRs & (v.rs == mEx.id.rt))
            | (uRt & (v.rt == mEx.id.rt)));
  endfunction

  task automatic cycle(input idv_t v, input logic fl,
                       input logic ho, output logic st);
    logic hz;
    exv_t nx, exp;
    drive(v);
    Flush  = fl;
    HoldEX = ho;
    @(negedge Clk);
    hz = modelHaz(v);
    st = (hz | ho) & ~fl;
    chk("stallIF", 256'(StallIF), 256'(st));
    if (fl)      nx = '0;
    else if (ho) nx = mEx;
    else if (hz) nx = '0;
    else begin
      nx.id    = v;
      nx.valid = 1'b1;
    end
    q.push_back(nx);
    @(posedge Clk);
    #1;
    exp = q.pop_front();
    chk("exRegs", 256'(readEx()), 256'(exp));
    mEx = exp;
  endtask

  task automatic issue(input idv_t v, input int expStalls,
                       input string tag);
    int   n;
    logic st;
    n = 0;
    cycle(v, 1'b0, 1'b0, st);
    while (st && n < 4) begin
      n++;
      cycle(v, 1'b0, 1'b0, st);
    end
    chk(tag, 256'(n), 256'(expStalls));
  endtask

  initial begin
    idv_t v;
    logic st;
    Rst    = 1'b0;
    Flush  = 1'b0;
    HoldEX = 1'b0;
    mEx    = '0;
    v = fAdd(5'd3, 5'd1, 5'd2);
    drive(v);
    repeat (3) @(posedge Clk);
    #1;
    chk("rstEx", 256'(readEx()), 256'(0));
    chk("rstStall", 256'(StallIF), 256'(0));
    Rst = 1'b1;

    v = fAdd(5'd3, 5'd1, 5'd2);
    v.rd1 = 32'd5;
    v.rd2 = 32'd7;
    issue(v, 0, "addStalls");
    chk("addAluOp", 256'(EX_ALUOp), 256'(4'b0010));
    chk("addRd", 256'(EX_Rd), 256'(5'd3));
    chk("addRd1", 256'(EX_ReadData1), 256'(32'd5));
    chk("addValid", 256'(EX_Valid), 256'(1'b1));

    issue(fLw(5'd4, 5'd1), 0, "lw4");
    issue(fAdd(5'd5, 5'd4, 5'd2), 1, "loadUse");
    chk("useValid", 256'(EX_Valid), 256'(1'b1));
    issue(fLw(5'd0, 5'd1), 0, "lw0");
    issue(fAdd(5'd5, 5'd0, 5'd2), 0, "lwZero");

    issue(fLw(5'd6, 5'd1), 0, "lw6a");
    issue(fAddi(5'd7, 5'd6), 1, "addiRs");
    issue(fLw(5'd6, 5'd1), 0, "lw6b");
    issue(fAddi(5'd6, 5'd2), 0, "addiRt");
    issue(fLw(5'd6, 5'd1), 0, "lw6c");
    issue(fSw(5'd6, 5'd2), 1, "swRt");

    issue(fLw(5'd8, 5'd1), 0, "lw8");
    issue(fLw(5'd9, 5'd8), 1, "lwDep");
    issue(fLw(5'd10, 5'd1), 0, "lwIndep");

    issue(fLw(5'd11, 5'd1), 0, "lw11");
    issue(fBeq(5'd2, 5'd11), 1, "beqRt");
    issue(fLw(5'd12, 5'd1), 0, "lw12");
    issue(fJ(5'd12), 0, "jNoUse");

    issue(fLw(5'd4, 5'd1), 0, "lw4f");
    cycle(fAdd(5'd5, 5'd4, 5'd2), 1'b1, 1'b1, st);
    chk("flushValid", 256'(EX_Valid), 256'(1'b0));
    chk("flushBt", 256'(EX_BranchType), 256'(2'd0));
    issue(base(5'd0, 5'd0, 5'd0), 0, "nop");

    issue(fMul(5'd3, 5'd1, 5'd2), 0, "mul");
    for (int i = 0; i < 3; i++) begin
      cycle(fAdd(5'(13 + i), 5'd1, 5'd2),
            1'b0, 1'b1, st);
      chk("holdAluOp", 256'(EX_ALUOp), 256'(4'b1111));
    end
    issue(fAdd(5'd20, 5'd1, 5'd2), 0, "release");
    chk("releaseRd", 256'(EX_Rd), 256'(5'd20));

    issue(fLw(5'd4, 5'd1), 0, "lw4r");
    drive(fAdd(5'd5, 5'd4, 5'd2));
    Flush  = 1'b0;
    HoldEX = 1'b0;
    @(negedge Clk);
    chk("preRstStall", 256'(StallIF), 256'(1'b1));
    #2 Rst = 1'b0;
    #1;
    chk("midRstEx", 256'(readEx()), 256'(0));
    chk("midRstStall", 256'(StallIF), 256'(0));
    #1 Rst = 1'b1;
    @(posedge Clk);
    #1;
    chk("postRstValid", 256'(EX_Valid), 256'(1'b1));
    chk("postRstRd", 256'(EX_Rd), 256'(5'd5));

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nMis);
    $finish;
  end

endmodule
